// File: rtl/ps2kb_pkg.sv
// ps2kb_pkg: shared constants, decoder state type and the set-2 -> set-1
// scancode table for the PS/2-to-XT keyboard bridge.
//   KB_FA/KB_F0/KB_E0/KB_E1 : keyboard ACK, break prefix, extended prefixes
//   KB_F11                  : set-2 F11 make code (pause hotkey)
//   dec_state_t             : prefix-tracking decoder state
//   ps2_set2_to_xt()        : 256-entry translation (make codes only)
package ps2kb_pkg;

  localparam logic [7:0] KB_FA  = 8'hFA;
  localparam logic [7:0] KB_F0  = 8'hF0;
  localparam logic [7:0] KB_E0  = 8'hE0;
  localparam logic [7:0] KB_E1  = 8'hE1;
  localparam logic [7:0] KB_F11 = 8'h78;

  // DEC_EXT after E0, DEC_E1 inside the E1 (Pause) sequence.
  typedef enum logic [1:0] {
    DEC_IDLE = 2'd0,
    DEC_EXT  = 2'd1,
    DEC_E1   = 2'd2
  } dec_state_t;

  // Unmapped codes at or above 8'h90 pass through; unmapped codes below
  // that have no set-1 equivalent and become 8'h00.
  function automatic logic [7:0] ps2_set2_to_xt(input logic [7:0] c);
    logic [7:0] r;
    case (c)
      8'h01: r = 8'h43; 8'h03: r = 8'h3F; 8'h04: r = 8'h3D; 8'h05: r = 8'h3B;
      8'h06: r = 8'h3C; 8'h07: r = 8'h58; 8'h09: r = 8'h44; 8'h0A: r = 8'h42;
      8'h0B: r = 8'h40; 8'h0C: r = 8'h3E; 8'h0D: r = 8'h0F; 8'h0E: r = 8'h29;
      8'h11: r = 8'h38; 8'h12: r = 8'h2A; 8'h14: r = 8'h1D; 8'h15: r = 8'h10;
      8'h16: r = 8'h02; 8'h1A: r = 8'h2C; 8'h1B: r = 8'h1F; 8'h1C: r = 8'h1E;
      8'h1D: r = 8'h11; 8'h1E: r = 8'h03; 8'h21: r = 8'h2E; 8'h22: r = 8'h2D;
      8'h23: r = 8'h20; 8'h24: r = 8'h12; 8'h25: r = 8'h05; 8'h26: r = 8'h04;
      8'h29: r = 8'h39; 8'h2A: r = 8'h2F; 8'h2B: r = 8'h21; 8'h2C: r = 8'h14;
      8'h2D: r = 8'h13; 8'h2E: r = 8'h06; 8'h31: r = 8'h31; 8'h32: r = 8'h30;
      8'h33: r = 8'h23; 8'h34: r = 8'h22; 8'h35: r = 8'h15; 8'h36: r = 8'h07;
      8'h3A: r = 8'h32; 8'h3B: r = 8'h24; 8'h3C: r = 8'h16; 8'h3D: r = 8'h08;
      8'h3E: r = 8'h09; 8'h41: r = 8'h33; 8'h42: r = 8'h25; 8'h43: r = 8'h17;
      8'h44: r = 8'h18; 8'h45: r = 8'h0B; 8'h46: r = 8'h0A; 8'h49: r = 8'h34;
      8'h4A: r = 8'h35; 8'h4B: r = 8'h26; 8'h4C: r = 8'h27; 8'h4D: r = 8'h19;
      8'h4E: r = 8'h0C; 8'h52: r = 8'h28; 8'h54: r = 8'h1A; 8'h55: r = 8'h0D;
      8'h58: r = 8'h3A; 8'h59: r = 8'h36; 8'h5A: r = 8'h1C; 8'h5B: r = 8'h1B;
      8'h5D: r = 8'h2B; 8'h61: r = 8'h56; 8'h66: r = 8'h0E; 8'h69: r = 8'h4F;
      8'h6B: r = 8'h4B; 8'h6C: r = 8'h47; 8'h70: r = 8'h52; 8'h71: r = 8'h53;
      8'h72: r = 8'h50; 8'h73: r = 8'h4C; 8'h74: r = 8'h4D; 8'h75: r = 8'h48;
      8'h76: r = 8'h01; 8'h77: r = 8'h45; 8'h78: r = 8'h57; 8'h79: r = 8'h4E;
      8'h7A: r = 8'h51; 8'h7B: r = 8'h4A; 8'h7C: r = 8'h37; 8'h7D: r = 8'h49;
      8'h7E: r = 8'h46; 8'h83: r = 8'h41;
      default: r = (c >= 8'h90) ? c : 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2kb_fifo.sv
// ps2kb_fifo: synchronous FIFO, power-of-two depth, extra-bit pointers.
//   clock, reset (async, active-high)
//   flush          : empties the queue (wins over wr_en/rd_en)
//   wr_en, wr_data : write; caller must not write when full unless reading
//   rd_en, rd_data : read; rd_data is the head, valid when !empty
//   full, empty, level
module ps2kb_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wptr, r_rptr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (wr_en) r_wptr <= r_wptr + PTR_ONE;
      if (rd_en) r_rptr <= r_rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) r_mem[r_wptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = r_mem[r_rptr[AW-1:0]];
  assign empty   = (r_wptr == r_rptr);
  // Same slot, opposite wrap bit.
  assign full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign level   = r_wptr - r_rptr;

endmodule

// File: rtl/ps2kb_xt_bridge.sv
// ps2kb_xt_bridge: PS/2 set-2 byte stream -> queued XT set-1 keycodes with
// irq/clear handshake toward the 8255/PIC.
//   clock, reset (async, active-high)
//   rx_valid, rx_data, rx_error : framed bytes / error strobe from the PS/2 receiver
//   clear_keycode               : host acknowledge, drops irq and keycode
//   reset_keyboard              : soft reset, flushes queue and presents BAT_CODE
//   irq, keycode                : presented set-1 byte
//   fifo_level                  : queued entries behind the presented keycode
//   overflow                    : sticky, a byte was dropped on a full queue
//   pause_core                  : core-pause request
// Build option PS2KB_PAUSE_HOTKEY_EN: F11 becomes a pause toggle on its break
// code and is never forwarded; while paused, all other keys are swallowed.
module ps2kb_xt_bridge
  import ps2kb_pkg::*;
#(
  parameter int         FIFO_DEPTH   = 8,
  parameter logic [7:0] OVERRUN_CODE = 8'hFF,
  parameter logic [7:0] BAT_CODE     = 8'hAA
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        rx_valid,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_error,
  input  logic                        clear_keycode,
  input  logic                        reset_keyboard,
  output logic                        irq,
  output logic [7:0]                  keycode,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic                        pause_core
);

  dec_state_t r_state, w_state_nxt;
  logic       r_brk, w_brk_nxt;
  logic       w_push;
  logic [7:0] w_push_data;
  logic [7:0] w_xl;
`ifdef PS2KB_PAUSE_HOTKEY_EN
  logic       r_pause, w_pause_nxt;
`endif

  logic       r_irq, r_ovf;
  logic [7:0] r_key;
  logic       w_full, w_empty, w_pop, w_wr, w_drop;
  logic [7:0] w_head;

  assign w_xl = ps2_set2_to_xt(rx_data);

  // Decoder next state and push request.
  always_comb begin
    w_state_nxt = r_state;
    w_brk_nxt   = r_brk;
    w_push      = 1'b0;
    w_push_data = 8'h00;
`ifdef PS2KB_PAUSE_HOTKEY_EN
    w_pause_nxt = r_pause;
`endif
    if (rx_error) begin
      w_push      = 1'b1;
      w_push_data = OVERRUN_CODE;
      w_brk_nxt   = 1'b0;
      w_state_nxt = DEC_IDLE;
    end else if (rx_valid) begin
`ifdef PS2KB_PAUSE_HOTKEY_EN
      if (r_pause && rx_data != KB_F0 && rx_data != KB_F11) begin
        w_brk_nxt   = 1'b0;
        w_state_nxt = DEC_IDLE;
      end else if (rx_data == KB_F11) begin
        if (r_brk) w_pause_nxt = ~r_pause;
        w_brk_nxt   = 1'b0;
        w_state_nxt = DEC_IDLE;
      end else
`endif
      begin
        case (rx_data)
          KB_FA: w_push = 1'b0;
          8'h00, 8'hFF: begin
            w_push      = 1'b1;
            w_push_data = OVERRUN_CODE;
            w_brk_nxt   = 1'b0;
            w_state_nxt = DEC_IDLE;
          end
          KB_F0: w_brk_nxt = 1'b1;
          KB_E0: begin
            w_push      = 1'b1;
            w_push_data = rx_data;
            w_state_nxt = DEC_EXT;
          end
          KB_E1: begin
            w_push      = 1'b1;
            w_push_data = rx_data;
            w_state_nxt = DEC_E1;
          end
          default: begin
            w_push      = 1'b1;
            w_push_data = w_xl | (r_brk ? 8'h80 : 8'h00);
            w_brk_nxt   = 1'b0;
            // Pause is E1 14 77; stay in DEC_E1 until the trailing 77.
            w_state_nxt = (r_state == DEC_E1 && rx_data == 8'h14) ? DEC_E1 : DEC_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= DEC_IDLE;
      r_brk   <= 1'b0;
    end else if (reset_keyboard) begin
      r_state <= DEC_IDLE;
      r_brk   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_brk   <= w_brk_nxt;
    end
  end

`ifdef PS2KB_PAUSE_HOTKEY_EN
  // A soft keyboard reset leaves the pause request alone.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)               r_pause <= 1'b0;
    else if (!reset_keyboard) r_pause <= w_pause_nxt;
  end
  assign pause_core = r_pause;
`else
  assign pause_core = 1'b0;
`endif

  // Pop is evaluated against the pre-push queue, so a same-cycle push is
  // never bypassed straight to keycode. A pop frees a slot for a push to a
  // full queue in the same cycle.
  assign w_pop  = !reset_keyboard && !clear_keycode && !r_irq && !w_empty;
  assign w_wr   = w_push && !reset_keyboard && (!w_full || w_pop);
  assign w_drop = w_push && !reset_keyboard && w_full && !w_pop;

  ps2kb_fifo #(.DEPTH(FIFO_DEPTH), .DW(8)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .flush   (reset_keyboard),
    .wr_en   (w_wr),
    .wr_data (w_push_data),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .level   (fifo_level)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_irq <= 1'b0;
      r_key <= 8'h00;
      r_ovf <= 1'b0;
    end else if (reset_keyboard) begin
      r_irq <= 1'b1;
      r_key <= BAT_CODE;
      r_ovf <= 1'b0;
    end else begin
      if (clear_keycode) begin
        r_irq <= 1'b0;
        r_key <= 8'h00;
      end else if (w_pop) begin
        r_irq <= 1'b1;
        r_key <= w_head;
      end
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  assign irq      = r_irq;
  assign keycode  = r_key;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_ps2kb_xt_bridge.sv
`timescale 1ns/1ps
module tb_ps2kb_xt_bridge;
  localparam int         DEPTH = 4;
  localparam logic [7:0] OVR   = 8'hFF;
  localparam logic [7:0] BAT   = 8'hAA;

  logic       clock = 1'b0, reset = 1'b1;
  logic       rx_valid = 1'b0, rx_error = 1'b0, clear_keycode = 1'b0, reset_keyboard = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       irq, overflow, pause_core;
  logic [7:0] keycode;
  logic [2:0] fifo_level;

  int n_chk = 0, n_fail = 0;
  logic [7:0] lit_q[$];

  always #5 clock = ~clock;

  ps2kb_xt_bridge #(.FIFO_DEPTH(DEPTH), .OVERRUN_CODE(OVR), .BAT_CODE(BAT)) dut (
    .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_error(rx_error), .clear_keycode(clear_keycode), .reset_keyboard(reset_keyboard),
    .irq(irq), .keycode(keycode), .fifo_level(fifo_level), .overflow(overflow),
    .pause_core(pause_core)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Set-2 -> set-1 for the keys this bench exercises.
  function automatic logic [7:0] xl(input logic [7:0] b);
    case (b)
      8'h1C: return 8'h1E; 8'h75: return 8'h48; 8'h7C: return 8'h37;
      8'h14: return 8'h1D; 8'h77: return 8'h45; 8'h78: return 8'h57;
      8'h83: return 8'h41; 8'h16: return 8'h02; 8'h1E: return 8'h03;
      8'h26: return 8'h04; 8'h25: return 8'h05; 8'h2E: return 8'h06;
      8'h36: return 8'h07; 8'h3D: return 8'h08;
      default: return (b >= 8'h90) ? b : 8'h00;
    endcase
  endfunction

  // Reference model: queue of pending set-1 bytes plus presented register.
  logic [7:0] m_q[$];
  logic [7:0] m_key = 8'h00;
  logic       m_irq = 1'b0, m_ovf = 1'b0, m_brk = 1'b0, m_pause = 1'b0;

  always begin : model
    logic       push, pop, pause_save;
    logic [7:0] pb;
    @(posedge clock);
    push = 1'b0;
    pb   = 8'h00;
    if (reset) begin
      m_q.delete(); m_key = 8'h00; m_irq = 1'b0; m_ovf = 1'b0; m_brk = 1'b0; m_pause = 1'b0;
    end else begin
      pause_save = m_pause;
      if (rx_error) begin
        push = 1'b1; pb = OVR; m_brk = 1'b0;
      end else if (rx_valid) begin
`ifdef PS2KB_PAUSE_HOTKEY_EN
        if (m_pause && rx_data != 8'hF0 && rx_data != 8'h78) m_brk = 1'b0;
        else if (rx_data == 8'h78) begin
          if (m_brk) m_pause = !m_pause;
          m_brk = 1'b0;
        end else
`endif
        begin
          if (rx_data == 8'hFA) push = 1'b0;
          else if (rx_data == 8'h00 || rx_data == 8'hFF) begin push = 1'b1; pb = OVR; m_brk = 1'b0; end
          else if (rx_data == 8'hF0) m_brk = 1'b1;
          else if (rx_data == 8'hE0 || rx_data == 8'hE1) begin push = 1'b1; pb = rx_data; end
          else begin push = 1'b1; pb = xl(rx_data) | (m_brk ? 8'h80 : 8'h00); m_brk = 1'b0; end
        end
      end
      if (reset_keyboard) begin
        m_q.delete(); m_brk = 1'b0; m_ovf = 1'b0; m_key = BAT; m_irq = 1'b1; m_pause = pause_save;
      end else begin
        pop = !clear_keycode && !m_irq && (m_q.size() > 0);
        if (clear_keycode) begin m_irq = 1'b0; m_key = 8'h00; end
        else if (pop) begin m_key = m_q.pop_front(); m_irq = 1'b1; end
        if (push) begin
          if (m_q.size() < DEPTH) m_q.push_back(pb);
          else m_ovf = 1'b1;
        end
      end
    end
    #1;
    chk("m_irq",   32'(irq),        32'(m_irq));
    chk("m_key",   32'(keycode),    32'(m_key));
    chk("m_level", 32'(fifo_level), 32'(m_q.size()));
    chk("m_ovf",   32'(overflow),   32'(m_ovf));
    chk("m_pause", 32'(pause_core), 32'(m_pause));
  end

  task automatic step(input int n = 1); repeat (n) @(negedge clock); endtask
  task automatic send(input logic [7:0] b); rx_valid = 1'b1; rx_data = b; step(); rx_valid = 1'b0; endtask
  task automatic err(); rx_error = 1'b1; step(); rx_error = 1'b0; endtask
  task automatic clr(); clear_keycode = 1'b1; step(); clear_keycode = 1'b0; endtask
  task automatic rstkb(); reset_keyboard = 1'b1; step(); reset_keyboard = 1'b0; endtask

  // Present/acknowledge every byte in lit_q, then confirm nothing follows.
  task automatic drain();
    for (int i = 0; i < lit_q.size(); i++) begin
      int t = 0;
      while (!irq && t < 10) begin step(); t++; end
      if (!irq) begin
        n_chk++; n_fail++;
        $display("FAIL drain_timeout: irq stayed 0 waiting for %0h", lit_q[i]);
      end
      chk($sformatf("drain%0d", i), 32'(keycode), 32'(lit_q[i]));
      clr();
    end
    step(3);
    chk("drain_idle", 32'(irq), 32'd0);
  endtask

  initial begin
    step(2);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_key", 32'(keycode), 32'h00);
    chk("rst_lvl", 32'(fifo_level), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_pause", 32'(pause_core), 32'd0);
    reset = 1'b0;
    step(2);

    // Make / break with 2-clock latency.
    send(8'h1C);
    chk("lat_make_n1", 32'(irq), 32'd0);
    @(posedge clock); #1;
    chk("lat_make_n2", 32'(irq), 32'd1);
    chk("make_key", 32'(keycode), 32'h1E);
    step();
    clr();
    chk("clr_irq", 32'(irq), 32'd0);
    chk("clr_key", 32'(keycode), 32'h00);
    send(8'hF0);
    send(8'h1C);
    chk("lat_brk_n1", 32'(irq), 32'd0);
    @(posedge clock); #1;
    chk("brk_key", 32'(keycode), 32'h9E);
    step();
    clr();

    // Extended key, queued.
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    chk("ext_lvl", 32'(fifo_level), 32'd3);
    chk("ext_head", 32'(keycode), 32'hE0);
    lit_q = '{8'hE0, 8'h48, 8'hE0, 8'hC8};
    drain();

    // E0 F0 7C and Pause sequence.
    send(8'hE0); send(8'hF0); send(8'h7C);
    lit_q = '{8'hE0, 8'hB7};
    drain();
    send(8'hE1); send(8'h14); send(8'h77);
    lit_q = '{8'hE1, 8'h1D, 8'h45};
    drain();
    send(8'hE1); send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    lit_q = '{8'hE1, 8'h9D, 8'hC5};
    drain();

    // Collision: clear and rx_valid together, queue non-empty.
    send(8'h16); send(8'h1E); step(2);
    rx_valid = 1'b1; rx_data = 8'h26; clear_keycode = 1'b1;
    step();
    rx_valid = 1'b0; clear_keycode = 1'b0;
    chk("col_irq_low", 32'(irq), 32'd0);
    chk("col_lvl", 32'(fifo_level), 32'd2);
    @(posedge clock); #1;
    chk("col_irq_back", 32'(irq), 32'd1);
    chk("col_key", 32'(keycode), 32'h03);
    chk("col_lvl2", 32'(fifo_level), 32'd1);
    step();
    lit_q = '{8'h03, 8'h04};
    drain();

    // Errors.
    err();
    lit_q = '{8'hFF};
    drain();
    send(8'hFA); step(3);
    chk("ack_irq", 32'(irq), 32'd0);
    chk("ack_lvl", 32'(fifo_level), 32'd0);
    send(8'h00);
    lit_q = '{8'hFF};
    drain();
    rx_valid = 1'b1; rx_error = 1'b1; rx_data = 8'h1C;
    step();
    rx_valid = 1'b0; rx_error = 1'b0;
    lit_q = '{8'hFF};
    drain();

    // Table corners.
    send(8'hA5); send(8'h83); send(8'hF0); send(8'h83);
    lit_q = '{8'hA5, 8'h41, 8'hC1};
    drain();

`ifdef PS2KB_PAUSE_HOTKEY_EN
    send(8'hF0); send(8'h78); step();
    chk("pause_on", 32'(pause_core), 32'd1);
    send(8'h1C); step(4);
    chk("pause_drop", 32'(irq), 32'd0);
    send(8'hF0); send(8'h78); step();
    chk("pause_off", 32'(pause_core), 32'd0);
    send(8'h78); step(4);
    chk("f11_make_drop", 32'(irq), 32'd0);
`else
    send(8'h78);
    lit_q = '{8'h57};
    drain();
`endif

    // Push to a full queue alongside a pop is accepted.
    send(8'h16); send(8'h1E); send(8'h26); send(8'h25); send(8'h2E); step();
    chk("full_lvl", 32'(fifo_level), 32'd4);
    chk("full_ovf", 32'(overflow), 32'd0);
    clr();
    send(8'h3D);
    chk("fullpop_lvl", 32'(fifo_level), 32'd4);
    chk("fullpop_ovf", 32'(overflow), 32'd0);
    chk("fullpop_key", 32'(keycode), 32'h03);
    rstkb();
    clr();
    step();

    // Overflow then soft keyboard reset.
    send(8'h16); send(8'h1E); send(8'h26); send(8'h25); send(8'h2E); send(8'h36); step();
    chk("ovf_key", 32'(keycode), 32'h02);
    chk("ovf_lvl", 32'(fifo_level), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    rstkb();
    chk("bat_key", 32'(keycode), 32'hAA);
    chk("bat_irq", 32'(irq), 32'd1);
    chk("bat_ovf", 32'(overflow), 32'd0);
    chk("bat_lvl", 32'(fifo_level), 32'd0);
    clr();
    step(2);
    chk("bat_clear", 32'(irq), 32'd0);

    // Asynchronous reset mid-prefix.
    send(8'hE0); send(8'hF0);
    reset = 1'b1;
    step();
    chk("arst_irq", 32'(irq), 32'd0);
    chk("arst_key", 32'(keycode), 32'h00);
    chk("arst_lvl", 32'(fifo_level), 32'd0);
    reset = 1'b0;
    step();
    send(8'h1C);
    lit_q = '{8'h1E};
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/ps2kb_xt_bridge.md
# ps2kb_xt_bridge

Buffered PS/2 scancode-set-2 to XT set-1 translator for the PC/XT keyboard path. It consumes framed bytes from the PS/2 receive shift register and tracks F0/E0/E1 prefixes. Translated bytes are queued in a parametrised FIFO and presented to the 8255/PIC side with an irq/clear handshake, so back-to-back multi-byte sequences (E0, Pause, Print Screen) are not lost while the host services the previous code.

## Interface
- FIFO_DEPTH, 8: entries in the output queue; power of two, ≥2.
- OVERRUN_CODE, 8'hFF: byte presented on receive error or invalid keyboard byte.
- BAT_CODE, 8'hAA: byte presented after reset_keyboard.

Ports. Reset is asynchronous and active-high; clock is `clock`.
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- rx_valid  in  1  one-cycle strobe: rx_data holds a complete PS/2 byte.
- rx_data  in  8  received set-2 byte.
- rx_error  in  1  one-cycle strobe: parity, stop-bit or timeout error.
- clear_keycode  in  1  host acknowledge (PB7 pulse): drops irq and the current keycode.
- reset_keyboard  in  1  soft keyboard reset (PB6 path).
- irq  out  1  keycode valid, IRQ1 request.
- keycode  out  8  current set-1 byte.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  queued entries, excluding the presented keycode.
- overflow  out  1  sticky: a byte was dropped because the queue was full.
- pause_core  out  1  core-pause request (see Configuration).

## Operation
- Reset values:
  - irq=0, keycode=8'h00, fifo_level=0, overflow=0, pause_core=0.
  - Decoder state is IDLE, with brk=0.
- Decoder, one transition per rx_valid:
  - 8'hFA (ACK): dropped, no state change.
  - 8'h00 or 8'hFF: push OVERRUN_CODE; brk←0.
  - 8'hF0: brk←1; nothing pushed.
  - 8'hE0 or 8'hE1: pushed unchanged; brk is preserved.
  - Any other byte: push translate(byte) | (brk ? 8'h80 : 0); brk←0.
- Resulting sequences:
  - E0 F0 7C → E0 B7.
  - E1 14 77 E1 F0 14 F0 77 → E1 1D 45 E1 9D C5.
- rx_error: push OVERRUN_CODE; brk←0.
- translate: 256-entry set-2→set-1 table.
  - Unmapped codes ≥8'h90 pass through unchanged.
  - Code 8'h83 (F7) maps to 8'h41.
- Push while the FIFO is full: the byte is dropped and overflow←1.
- Pop: when irq=0 and the FIFO is not empty, keycode←head and irq←1.
- clear_keycode: irq←0, keycode←8'h00. A pop may occur on the following cycle.
- reset_keyboard:
  - Flush the FIFO; decoder→IDLE; brk←0; overflow←0.
  - keycode←BAT_CODE, irq←1.
  - pause_core is unchanged.
- Priority: reset_keyboard > clear_keycode > pop. Push runs in parallel with all three except reset_keyboard, which discards a same-cycle push.

## Timing
- rx_valid at cycle N: the FIFO write is committed at the N edge; fifo_level reflects it at N+1.
- With irq=0 and the FIFO empty, irq and keycode update at the N+1 edge. Latency is 2 clocks from rx_valid to irq.
- Simultaneous push and pop: fifo_level is unchanged. A push to a full FIFO in the same cycle as a pop is accepted.
- Pop is blocked in any cycle with clear_keycode=1. irq stays 0 for ≥1 cycle between consecutive codes.
- rx_valid and rx_error in the same cycle: rx_error wins and rx_data is ignored.
- Asynchronous reset mid-sequence: all state returns to reset values; a partial E0/F0 prefix is lost.

## Configuration
- PS2KB_PAUSE_HOTKEY_EN defined:
  - Set-2 8'h78 (F11) is never pushed.
  - The F11 break (F0 78) toggles pause_core.
  - While pause_core=1, every byte other than F0 and 78 is dropped and brk is cleared.
- Not defined: pause_core is tied 0, and 8'h78 translates normally to 8'h57.

## Structure
- Package ps2kb_pkg:
  - Prefix constants: FA, F0, E0, E1, F11=8'h78.
  - Decoder state enum.
  - Function ps2_set2_to_xt(byte).
- Sub-module ps2kb_fifo:
  - Synchronous FIFO with power-of-two depth, extra-bit pointers, flush input.
  - Outputs: full, empty, level.

## Test plan
- Make/break: rx 1C, then F0 1C, each followed by clear_keycode → keycode 1E then 9E, irq 2 clocks after each rx_valid.
- Extended key: rx E0 75 E0 F0 75 with no clear until all are received → queue delivers E0 48 E0 C8 in order; fifo_level peaks at 3.
- Overflow: FIFO_DEPTH=4, 6 make codes with no clear → first code presented, 4 queued, 6th dropped, overflow=1; reset_keyboard → keycode AA, irq=1, overflow=0, fifo_level=0.
- Errors: rx_error strobe → keycode FF; rx FA → nothing presented; rx 00 → FF.
- Pause hotkey (macro on): F0 78 → pause_core=1; rx 1C → dropped; F0 78 → pause_core=0. Macro off: rx 78 → keycode 57.
- Collision: clear_keycode in the same cycle as rx_valid with a non-empty queue → irq low for exactly one cycle, then the next code is presented and the new byte is queued.
